address_unpack: RTL and testbench

ADDRESS_UNPACK -- requirements
Module: address_unpack

---
 rtl/address_unpack.sv | 92 +++++++++
 tb/tb_address_unpack.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/address_unpack.sv
// address_unpack: splits a linear address into column (X) and row (Y) by restoring division by BLOCK_SIZE
// Ports:
//   Clk, Reset        clock and synchronous active-high reset
//   Address, Start    linear address and request (accepted only while Ready=1)
//   OutputX, OutputY  Address mod BLOCK_SIZE, Address div BLOCK_SIZE (low DATA_WIDTH bits)
//   Ready, Overflow   idle flag, and quotient-did-not-fit flag
module address_unpack #(
    parameter int DATA_WIDTH = 16,
    parameter int BLOCK_SIZE = 10
) (
    input  logic                    Clk,
    input  logic                    Reset,
    input  logic [2*DATA_WIDTH-1:0] Address,
    input  logic                    Start,
    output logic [DATA_WIDTH-1:0]   OutputX,
    output logic [DATA_WIDTH-1:0]   OutputY,
    output logic                    Ready,
    output logic                    Overflow
);
    localparam int AW = 2 * DATA_WIDTH;
    // remainder stays below BLOCK_SIZE, so after the shift it is below 2*BLOCK_SIZE
    localparam int RW = $clog2(BLOCK_SIZE) + 1;
    localparam int CW = $clog2(AW + 1);
    localparam logic [RW:0] BS = (RW + 1)'(BLOCK_SIZE);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t                  state_q, state_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [RW-1:0]           rem_q, rem_d;
    // dividend shifts out at the top while quotient bits shift in at the bottom
    logic [AW-1:0]           div_q, div_d;
    logic [DATA_WIDTH-1:0]   x_q, x_d, y_q, y_d;
    logic                    ovf_q, ovf_d;
    logic [RW:0]             trial;
    logic                    take;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        div_d   = div_q;
        x_d     = x_q;
        y_d     = y_q;
        ovf_d   = ovf_q;
        trial   = {rem_q, div_q[AW-1]};
        take    = trial >= BS;
        if (state_q == IDLE) begin
            if (Start) begin
                state_d = BUSY;
                cnt_d   = CW'(AW);
                rem_d   = '0;
                div_d   = Address;
            end
        end else begin
            rem_d = take ? RW'(trial - BS) : RW'(trial);
            div_d = {div_q[AW-2:0], take};
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
                state_d = IDLE;
                x_d     = DATA_WIDTH'(rem_d);
                y_d     = div_d[DATA_WIDTH-1:0];
                ovf_d   = |div_d[AW-1:DATA_WIDTH];
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            div_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            div_q   <= div_d;
            x_q     <= x_d;
            y_q     <= y_d;
            ovf_q   <= ovf_d;
        end
    end

    assign Ready    = state_q == IDLE;
    assign OutputX  = x_q;
    assign OutputY  = y_q;
    assign Overflow = ovf_q;
endmodule

// File: tb/tb_address_unpack.sv
// tb_address_unpack: scoreboard bench for address_unpack (DATA_WIDTH=16, BLOCK_SIZE=10)
module tb_address_unpack;
    logic        Clk = 0;
    logic        Reset = 1;
    logic [31:0] Address = '0;
    logic        Start = 0;
    logic [15:0] OutputX, OutputY;
    logic        Ready, Overflow;

    typedef struct {
        logic [15:0] x;
        logic [15:0] y;
        logic        ovf;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    bit   b2b = 0;

    address_unpack #(.DATA_WIDTH(16), .BLOCK_SIZE(10)) dut (
        .Clk(Clk), .Reset(Reset), .Address(Address), .Start(Start),
        .OutputX(OutputX), .OutputY(OutputY), .Ready(Ready), .Overflow(Overflow)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic wait_ready(input logic val, input string name);
        for (int i = 0; i < 200; i++) begin
            if (Ready === val) return;
            tick();
        end
        checks++;
        errors++;
        $display("FAIL %s: timeout waiting for Ready=%0d", name, val);
    endtask

    task automatic req(input logic [31:0] addr, input logic [15:0] x, input logic [15:0] y,
                       input logic ovf);
        exp_t e;
        wait_ready(1'b1, "req_ready");
        e.x = x;
        e.y = y;
        e.ovf = ovf;
        sb.push_back(e);
        Address = addr;
        Start = 1;
        tick();
        Start = 0;
    endtask

    // monitor: results are popped when Ready returns high after a busy run
    initial begin
        bit          rst_seen = 0;
        int          busy = 0;
        int          idle_run = 0;
        logic [15:0] last_x = 0, last_y = 0;
        logic        last_ovf = 0;
        exp_t        e;
        forever begin
            @(negedge Clk);
            if (rst_seen) begin
                chk("reset_ready", 32'(Ready), 1);
                chk("reset_x", 32'(OutputX), 0);
                chk("reset_y", 32'(OutputY), 0);
                chk("reset_ovf", 32'(Overflow), 0);
                last_x = 0;
                last_y = 0;
                last_ovf = 0;
                busy = 0;
                idle_run = 0;
            end else if (!Ready) begin
                if (busy == 0 && b2b) begin
                    chk("b2b_idle_cycles", 32'(idle_run), 1);
                    b2b = 0;
                end
                chk("hold_x", 32'(OutputX), 32'(last_x));
                chk("hold_y", 32'(OutputY), 32'(last_y));
                chk("hold_ovf", 32'(Overflow), 32'(last_ovf));
                busy++;
            end else if (busy > 0) begin
                chk("latency", 32'(busy), 32);
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_result: x=%0d y=%0d", OutputX, OutputY);
                end else begin
                    e = sb.pop_front();
                    chk("x", 32'(OutputX), 32'(e.x));
                    chk("y", 32'(OutputY), 32'(e.y));
                    chk("ovf", 32'(Overflow), 32'(e.ovf));
                    last_x = e.x;
                    last_y = e.y;
                    last_ovf = e.ovf;
                end
                busy = 0;
                idle_run = 1;
            end else begin
                idle_run++;
            end
            rst_seen = Reset;
        end
    end

    initial begin
        logic [15:0] rx, ry;
        tick();
        tick();
        Reset = 0;
        tick();
        req(54, 4, 5, 0);
        req(0, 0, 0, 0);
        req(9, 9, 0, 0);
        req(10, 0, 1, 0);
        req(655359, 9, 65535, 0);
        req(655360, 0, 0, 1);
        req(32'hFFFF_FFFF, 5, 16'h9999, 1);
        // request ignored while busy
        req(54, 4, 5, 0);
        repeat (4) tick();
        Address = 999;
        Start = 1;
        tick();
        Start = 0;
        // reset mid-operation, with Start asserted in the same edge
        wait_ready(1'b1, "pre_abort");
        Address = 54;
        Start = 1;
        tick();
        Start = 0;
        repeat (9) tick();
        Reset = 1;
        Start = 1;
        tick();
        Reset = 0;
        Start = 0;
        chk("abort_ready", 32'(Ready), 1);
        tick();
        chk("abort_no_restart", 32'(Ready), 1);
        req(123, 3, 12, 0);
        // Start held high: two back-to-back operations
        wait_ready(1'b1, "b2b_start");
        sb.push_back('{x: 7, y: 7, ovf: 0});
        sb.push_back('{x: 7, y: 7, ovf: 0});
        Address = 77;
        Start = 1;
        tick();
        wait_ready(1'b1, "b2b_done1");
        b2b = 1;
        wait_ready(1'b0, "b2b_accept2");
        Start = 0;
        // round trip against a linear-address model: addr = y*10 + x
        for (int i = 0; i < 1000; i++) begin
            rx = 16'($urandom_range(9, 0));
            ry = 16'($urandom_range(65535, 0));
            req(32'(ry) * 10 + 32'(rx), rx, ry, 0);
        end
        for (int i = 0; i < 200 && sb.size() != 0; i++) tick();
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d results outstanding", sb.size());
        end
        chk("b2b_checked", 32'(b2b), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
